kbd_spi_matrix: RTL and testbench

KBD_SPI_MATRIX -- requirements
Module: kbd_spi_matrix

---
 rtl/kbd_spi_matrix.sv | 94 +++++++++
 tb/tb_kbd_spi_matrix.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/kbd_spi_matrix.sv
// SPI keyboard receiver: shifts 40-bit frames from an external controller into
// a key matrix register and serves port #FE column reads from it.
module kbd_spi_matrix #(
  parameter int SYNC_STAGES = 2,
  parameter int ERR_W       = 4
) (
  input  logic             CLK_14MHZ,
  input  logic             CPU_RESET,
  input  logic             KBD_CLK,
  input  logic             KBD_CS,
  input  logic             KBD_DI,
  input  logic [7:0]       A_HI,
  output logic [4:0]       KB,
  output logic             FRAME_OK,
  output logic [ERR_W-1:0] ERR_CNT
);

  localparam int L = SYNC_STAGES - 1;
  localparam int P = SYNC_STAGES - 2;

  typedef enum logic [1:0] {IDLE, SHIFT, OVER} state_t;

  logic [SYNC_STAGES-1:0] clk_s, cs_s, di_s, sync_vld;
  logic [39:0]            sr, m;
  logic [5:0]             bc;
  logic                   armed;
  state_t                 state;
  logic                   clk_rise, cs_rise, cs_fall;

  always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
    if (!CPU_RESET) begin
      clk_s    <= '1;
      cs_s     <= '1;
      di_s     <= '1;
      sync_vld <= '0;
    end else begin
      clk_s    <= {clk_s[P:0], KBD_CLK};
      cs_s     <= {cs_s[P:0], KBD_CS};
      di_s     <= {di_s[P:0], KBD_DI};
      sync_vld <= {sync_vld[P:0], 1'b1};
    end
  end

  assign clk_rise = clk_s[P] & ~clk_s[L];
  assign cs_rise  = cs_s[P] & ~cs_s[L];
  assign cs_fall  = ~cs_s[P] & cs_s[L];

  // Arming waits for the synchronizer to hold real samples, so a reset inside a
  // frame cannot mistake the reset value of the CS chain for a frame start.
  always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
    if (!CPU_RESET) begin
      sr       <= '0;
      bc       <= '0;
      m        <= '1;
      armed    <= 1'b0;
      state    <= IDLE;
      FRAME_OK <= 1'b0;
      ERR_CNT  <= '0;
    end else begin
      FRAME_OK <= 1'b0;
      if (!armed) begin
        if (sync_vld[L] && cs_s[P])
          armed <= 1'b1;
      end else if (cs_rise) begin
        state <= IDLE;
        if (state == SHIFT && bc == 6'd40) begin
          m        <= sr;
          FRAME_OK <= 1'b1;
        end else if (state != IDLE && ERR_CNT != '1) begin
          ERR_CNT <= ERR_CNT + 1'b1;
        end
      end else if (cs_fall) begin
        state <= SHIFT;
        bc    <= '0;
      end else if (clk_rise && state == SHIFT) begin
        if (bc == 6'd40) begin
          state <= OVER;
        end else begin
          sr <= {sr[38:0], di_s[L]};
          bc <= bc + 6'd1;
        end
      end
    end
  end

  always_comb begin
    KB = '1;
    for (int unsigned r = 0; r < 8; r++) begin
      if (!A_HI[r])
        KB = KB & m[r*5 +: 5];
    end
  end

endmodule

// File: tb/tb_kbd_spi_matrix.sv
// Directed bench for kbd_spi_matrix: a key-level matrix model checked every
// cycle between frames, plus hand-computed literal expectations.
module tb_kbd_spi_matrix;

  logic       clk = 1'b0;
  logic       CPU_RESET;
  logic       KBD_CLK, KBD_CS, KBD_DI;
  logic [7:0] A_HI;
  logic [4:0] KB;
  logic       FRAME_OK;
  logic [3:0] ERR_CNT;

  int errors = 0;
  int checks = 0;

  logic [39:0] model_m;
  int          model_err;
  int          fo_exp;
  int          fo_seen = 0;
  logic        fo_prev = 1'b0;
  logic        chk_en;

  kbd_spi_matrix #(.SYNC_STAGES(2), .ERR_W(4)) dut (
    .CLK_14MHZ(clk),
    .CPU_RESET(CPU_RESET),
    .KBD_CLK(KBD_CLK),
    .KBD_CS(KBD_CS),
    .KBD_DI(KBD_DI),
    .A_HI(A_HI),
    .KB(KB),
    .FRAME_OK(FRAME_OK),
    .ERR_CNT(ERR_CNT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A pressed key (0) in a selected half-row pulls its column low.
  function automatic logic [4:0] kb_model(input logic [39:0] mm, input logic [7:0] a);
    logic [4:0] kb;
    kb = 5'h1F;
    for (int k = 0; k < 40; k++)
      if (!mm[k] && !a[k / 5]) kb[k % 5] = 1'b0;
    return kb;
  endfunction

  always @(negedge clk) begin
    if (FRAME_OK) begin
      fo_seen++;
      chk("frame_ok_width", {63'd0, fo_prev}, 64'd0);
    end
    fo_prev = FRAME_OK;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("kb", {59'd0, KB}, {59'd0, kb_model(model_m, A_HI)});
      chk("err_cnt", {60'd0, ERR_CNT}, 64'(model_err));
      chk("frame_ok_idle", {63'd0, FRAME_OK}, 64'd0);
      chk("frame_ok_count", 64'(fo_seen), 64'(fo_exp));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic with_cs);
    KBD_DI = b;
    cyc(6);
    KBD_CLK = 1'b1;
    if (with_cs) KBD_CS = 1'b1;
    cyc(6);
    KBD_CLK = 1'b0;
  endtask

  // Sends n bits MSB first; with merge the last clock rise coincides with CS rise.
  task automatic send_frame(input logic [63:0] bits, input int n, input logic merge);
    int eff;
    KBD_CS = 1'b0;
    cyc(8);
    for (int i = n - 1; i >= 0; i--) begin
      if (merge && i == 0) begin
        chk_en = 1'b0;
        send_bit(bits[i], 1'b1);
      end else begin
        send_bit(bits[i], 1'b0);
      end
    end
    chk_en = 1'b0;
    KBD_CS = 1'b1;
    cyc(10);
    eff = merge ? n - 1 : n;
    if (eff == 40) begin
      model_m = bits[39:0];
      fo_exp++;
    end else if (model_err < 15) begin
      model_err++;
    end
    chk_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    CPU_RESET = 1'b0;
    KBD_CLK   = 1'b0;
    KBD_CS    = 1'b1;
    KBD_DI    = 1'b1;
    A_HI      = 8'hFF;
    chk_en    = 1'b0;
    model_m   = '1;
    model_err = 0;
    fo_exp    = 0;
    cyc(3);
    CPU_RESET = 1'b1;
    cyc(10);

    A_HI = 8'h00; #1;
    chk("reset_kb", {59'd0, KB}, 64'h1F);
    chk("reset_err", {60'd0, ERR_CNT}, 64'h0);
    chk("reset_fo", {63'd0, FRAME_OK}, 64'h0);
    chk_en = 1'b1;

    send_frame(64'hFF_FFFF_FFFE, 40, 1'b0);
    chk("fo_after_first", 64'(fo_seen), 64'd1);
    A_HI = 8'hFE; #1;
    chk("row0_col0", {59'd0, KB}, 64'h1E);
    A_HI = 8'hFD; #1;
    chk("row1_clear", {59'd0, KB}, 64'h1F);

    send_frame(64'h7F_FFFF_FFFF, 40, 1'b0);
    A_HI = 8'h7E; #1;
    chk("row7_col4", {59'd0, KB}, 64'h0F);

    send_frame(64'h7F_FFFF_FFFE, 40, 1'b0);
    A_HI = 8'h00; #1;
    chk("rows0_7", {59'd0, KB}, 64'h0E);

    send_frame(64'h0, 39, 1'b0);
    send_frame(64'h0, 41, 1'b0);
    send_frame(64'h0, 0, 1'b0);
    chk("err_three", {60'd0, ERR_CNT}, 64'h3);
    chk("m_kept", {59'd0, KB}, 64'h0E);
    chk("fo_after_bad", 64'(fo_seen), 64'd3);

    for (int i = 0; i < 12; i++) send_frame(64'h0, 0, 1'b0);
    chk("err_full", {60'd0, ERR_CNT}, 64'hF);
    send_frame(64'h0, 0, 1'b0);
    chk("err_saturate", {60'd0, ERR_CNT}, 64'hF);

    KBD_CS = 1'b0;
    cyc(8);
    for (int i = 0; i < 20; i++) send_bit(1'b0, 1'b0);
    chk_en = 1'b0;
    CPU_RESET = 1'b0;
    model_m   = '1;
    model_err = 0;
    cyc(3);
    CPU_RESET = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < 20; i++) send_bit(1'b0, 1'b0);
    KBD_CS = 1'b1;
    cyc(10);
    chk("abort_err", {60'd0, ERR_CNT}, 64'h0);
    chk("abort_kb", {59'd0, KB}, 64'h1F);

    send_frame(64'h12_3456_789A, 40, 1'b0);
    A_HI = 8'hFE; #1;
    chk("post_reset_row0", {59'd0, KB}, 64'h1A);
    A_HI = 8'h7F; #1;
    chk("post_reset_row7", {59'd0, KB}, 64'h02);

    A_HI = 8'hFE;
    send_frame(64'h00_0000_0000, 40, 1'b1);
    chk("merge_err", {60'd0, ERR_CNT}, 64'h1);
    chk("merge_kept", {59'd0, KB}, 64'h1A);

    cyc(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
